// File: rtl/muldiv_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// The master drives the request fields and the slave returns status and results.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, op1, op2, input busy, done, hi, lo);
  modport slave  (input start, op, op1, op2, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per clock on operand magnitudes with sign correction at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1111;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_hi;   // negate product, or remainder (dividend sign)
  logic             neg_lo;   // negate quotient
  logic [WIDTH-1:0] acc;      // product upper half / partial remainder
  logic [WIDTH-1:0] lo_w;     // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] m;        // multiplicand / divisor magnitude

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Request decode, only meaningful when a start is accepted.
  logic             op_signed;
  logic             op_is_div;
  logic             s1, s2;
  logic             op2_zero;

  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign op_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign s1        = op_signed & bus.op1[WIDTH-1];
  assign s2        = op_signed & bus.op2[WIDTH-1];
  assign op2_zero  = (bus.op2 == '0);

  // One iteration of either algorithm, plus the sign-corrected final result.
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   lo_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, (lo_w[0] ? m : '0)};
    shifted  = {acc, lo_w[WIDTH-1]};
    ge       = (shifted >= {1'b0, m});
    diff     = shifted[WIDTH-1:0] - m;
    acc_nxt  = sum[WIDTH:1];
    lo_nxt   = {sum[0], lo_w[WIDTH-1:1]};
    if (is_div) begin
      // A zero divisor always "fits", giving all-ones quotient and the dividend as remainder.
      acc_nxt = ge ? diff : shifted[WIDTH-1:0];
      lo_nxt  = {lo_w[WIDTH-2:0], ge};
    end
    prod     = {acc_nxt, lo_nxt};
    prod_fix = neg_hi ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_hi ? -acc_nxt : acc_nxt;
      res_lo = neg_lo ? -lo_nxt : lo_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath working registers are not reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      case (state)
        RUN: begin
          acc  <= acc_nxt;
          lo_w <= lo_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            bus.hi   <= res_hi;
            bus.lo   <= res_lo;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE never lasts past one cycle.
          bus.done <= 1'b0;
          state    <= IDLE;
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div   <= op_is_div;
                neg_hi   <= op_is_div ? s1 : (s1 ^ s2);
                neg_lo   <= (s1 ^ s2) & ~op2_zero;
                acc      <= '0;
                lo_w     <= magnitude(bus.op1, s1);
                m        <= magnitude(bus.op2, s2);
                cnt      <= '0;
                bus.busy <= 1'b1;
                state    <= RUN;
              end
              OP_MTHI: bus.hi <= bus.op1;
              OP_MTLO: bus.lo <= bus.op1;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
